// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader state encodings and memory-map constants shared by the loader and the instruction memory
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, BASE, COUNT, DATA, CHECK, DONE, ERROR} state_t;
  localparam logic [31:0] IMEM_BASE = 32'h0040_0000;
  localparam logic [31:0] LOADER_MAGIC = 32'h4D49_5053;
  localparam int IMEM_WORDS = 1024;
endpackage

// File: rtl/imem_loader_checksum.sv
// loader_checksum: mod-2^32 running sum of data words with clear/add enables
module loader_checksum (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        add,
  input  logic [31:0] data,
  output logic [31:0] sum
);
  always_ff @(posedge clock)
    if (reset || clr) sum <= '0;
    else if (add) sum <= sum + data;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a framed word stream into instruction memory and holds the CPU until the image is in place.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum word after the data.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = IMEM_BASE,
  parameter int          MAX_WORDS = IMEM_WORDS,
  parameter logic [31:0] MAGIC     = LOADER_MAGIC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [31:0] words_written
);
  // 35 bits so base + 4*N can never wrap, whatever N the host sends
  localparam logic [34:0] WIN_END = 35'(MEM_BASE) + (35'(MAX_WORDS) << 2);
  state_t state, next;
  logic [31:0] base, count, idx;
  logic fire, base_bad, count_bad, last;
  assign fire = in_valid && in_ready;
  assign last = idx == count - 32'd1;
  assign base_bad = in_data[1:0] != 2'b00 || in_data < MEM_BASE || {3'b0, in_data} >= WIN_END;
  assign count_bad = in_data == '0 || ({3'b0, base} + {1'b0, in_data, 2'b00}) > WIN_END;
  assign in_ready = !(state inside {DONE, ERROR});
  // Release the CPU only once the last registered write has left the loader
  assign load_done = state == DONE && !wr_en;
  assign load_error = state == ERROR;
  assign cpu_hold = !load_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t DATA_NEXT = CHECK;
  logic [31:0] sum;
  loader_checksum u_sum (
    .clock(clock),
    .reset(reset),
    .clr(fire && state == COUNT),
    .add(fire && state == DATA),
    .data(in_data),
    .sum(sum)
  );
`else
  localparam state_t DATA_NEXT = DONE;
`endif
  always_comb begin
    next = state;
    if (fire)
      case (state)
        IDLE:  next = in_data == MAGIC ? BASE : IDLE;
        BASE:  next = base_bad ? ERROR : COUNT;
        COUNT: next = count_bad ? ERROR : DATA;
        DATA:  next = last ? DATA_NEXT : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: next = in_data == sum ? DONE : ERROR;
`endif
        default: next = state;
      endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      words_written <= '0;
      base <= '0;
      count <= '0;
      idx <= '0;
    end else begin
      state <= next;
      wr_en <= fire && state == DATA;
      if (fire && state == BASE) base <= in_data;
      if (fire && state == COUNT) begin
        count <= in_data;
        idx <= '0;
        words_written <= '0;
      end
      if (fire && state == DATA) begin
        wr_addr <= base + (idx << 2);
        wr_data <= in_data;
        idx <= idx + 32'd1;
        words_written <= words_written + 32'd1;
      end
    end
  end
endmodule
